cdb_arbiter: RTL

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/rv32i_types.sv | 21 ++
 rtl/cdb_fu_fifo.sv | 62 ++++++
 rtl/cdb_arbiter.sv | 91 +++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I core types: functional-unit result payload and the common data bus
// broadcast consumed by the ROB, RAT and reservation stations.
package rv32i_types;

    localparam int NUM_FU         = 4;
    localparam int CDB_FIFO_DEPTH = 2;

    typedef struct packed {
        logic [4:0]  rd_addr;
        logic [4:0]  rob_idx;
        logic [31:0] data;
    } fu_result_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd_addr;
        logic [4:0]  rob_idx;
        logic [31:0] data;
    } cdb_t;

endpackage

// File: rtl/cdb_fu_fifo.sv
// Per-functional-unit result buffer in front of the CDB arbiter.
// Ready depends only on the registered occupancy count.
module cdb_fu_fifo
    import rv32i_types::*;
#(
    parameter  int DEPTH = CDB_FIFO_DEPTH,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  fu_result_t       din,
    output fu_result_t       head,
    output logic [CNT_W-1:0] count,
    output logic             ready
);

    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    fu_result_t       mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign ready   = (count < CNT_W'(DEPTH));
    assign do_push = push && ready && !flush;
    assign do_pop  = pop && (count != '0) && !flush;
    assign head    = mem[head_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (do_push) tail_ptr <= wrap_inc(tail_ptr);
            if (do_pop)  head_ptr <= wrap_inc(head_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; count gates every read, so stale entries are never observed.
    always_ff @(posedge clk) begin
        if (do_push) mem[tail_ptr] <= din;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers per-FU results and broadcasts one per cycle,
// chosen round-robin, through a registered cdbus.
module cdb_arbiter
    import rv32i_types::*;
#(
    parameter int NUM_FU     = 4,
    parameter int FIFO_DEPTH = CDB_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic       [NUM_FU-1:0]       fu_valid,
    input  fu_result_t [NUM_FU-1:0]       fu_result,
    output logic       [NUM_FU-1:0]       fu_ready,
    output cdb_t                          cdbus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic       [NUM_FU-1:0] push;
    logic       [NUM_FU-1:0] pop;
    logic       [NUM_FU-1:0] not_empty;
    fu_result_t [NUM_FU-1:0] head;
    logic       [CNT_W-1:0]  count [NUM_FU];

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] rr_next;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;
    int               idx;

    assign push = fu_valid & fu_ready & {NUM_FU{~flush}};

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fifo
        cdb_fu_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .push  (push[i]),
            .pop   (pop[i]),
            .din   (fu_result[i]),
            .head  (head[i]),
            .count (count[i]),
            .ready (fu_ready[i])
        );
        assign not_empty[i] = (count[i] != '0);
    end

    // First non-empty buffer at or above rr_ptr, wrapping past NUM_FU-1.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < NUM_FU; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_FU) idx = idx - NUM_FU;
            if (!grant_valid && not_empty[IDX_W'(idx)]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        pop = '0;
        if (grant_valid && !flush) pop[grant_idx] = 1'b1;
    end

    assign rr_next = (grant_idx == IDX_W'(NUM_FU - 1)) ? '0 : grant_idx + IDX_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
            cdbus  <= '0;
        end else if (flush) begin
            rr_ptr      <= '0;
            cdbus.valid <= 1'b0;
        end else begin
            cdbus.valid <= grant_valid;
            if (grant_valid) begin
                rr_ptr        <= rr_next;
                cdbus.rd_addr <= head[grant_idx].rd_addr;
                cdbus.rob_idx <= head[grant_idx].rob_idx;
                cdbus.data    <= head[grant_idx].data;
            end
        end
    end

endmodule
